// File: rtl/banco_registrador_placar_pkg.sv
// Shared constants for the register bank and its scoreboard.
// Decode and writeback import the same defaults so widths stay consistent.
package banco_registrador_placar_pkg;

    localparam int XLEN_DEFAULT       = 32;
    localparam int AMOUNT_DEFAULT     = 16;
    localparam int ADDRESSLEN_DEFAULT = 4;

    // Index of the hardwired-zero register; it is never written nor reserved.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/banco_registrador_placar_placar_registrador.sv
// Scoreboard of pending writes: one busy bit per register plus a running
// count of set bits. Priority within a cycle is flush, then release by the
// writeback port, then reservation by decode, so a new producer always wins.
module placar_registrador
    import banco_registrador_placar_pkg::*;
#(
    parameter int AMOUNT     = AMOUNT_DEFAULT,
    parameter int ADDRESSLEN = ADDRESSLEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wEn,
    input  logic [ADDRESSLEN-1:0] rd,
    input  logic                  resEn,
    input  logic [ADDRESSLEN-1:0] resAddr,
    input  logic                  flush,
    output logic [AMOUNT-1:0]     busy,
    output logic [ADDRESSLEN:0]   pendingCount
);

    localparam logic [ADDRESSLEN-1:0] ZERO_ADDR = ADDRESSLEN'(ZERO_REG);

    logic [AMOUNT-1:0]   busy_next;
    logic [ADDRESSLEN:0] count_next;

    // Next busy vector: flush clears everything, release clears rd, reserve sets resAddr last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        busy_next = flush ? '0 : busy;
        if (wEn && rd != ZERO_ADDR) begin
            busy_next[rd] = 1'b0;
        end
        if (resEn && resAddr != ZERO_ADDR) begin
            busy_next[resAddr] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    // Population count of the next busy vector, so the count updates with busy.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < AMOUNT; i++) begin
            count_next = count_next + (ADDRESSLEN+1)'(busy_next[i]);
        end
    end

    // Busy vector and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= '0;
            pendingCount <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            busy         <= busy_next;
            pendingCount <= count_next;
        end
    end

endmodule

// File: rtl/banco_registrador_placar.sv
// Register bank with two registered read ports, write-to-read bypass, one
// write port and an integrated pending-write scoreboard. Register 0 reads
// as zero and is never reserved. All outputs come straight from flops.
module banco_registrador_placar
    import banco_registrador_placar_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int AMOUNT     = AMOUNT_DEFAULT,
    parameter int ADDRESSLEN = ADDRESSLEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rEn,
    input  logic [ADDRESSLEN-1:0] rs1,
    input  logic [ADDRESSLEN-1:0] rs2,
    output logic [XLEN-1:0]       r1,
    output logic [XLEN-1:0]       r2,
    output logic                  r1Busy,
    output logic                  r2Busy,
    input  logic                  wEn,
    input  logic [ADDRESSLEN-1:0] rd,
    input  logic [XLEN-1:0]       data,
    input  logic                  resEn,
    input  logic [ADDRESSLEN-1:0] resAddr,
    input  logic                  flush,
    output logic [AMOUNT-1:0]     busy,
    output logic [ADDRESSLEN:0]   pendingCount
);

    localparam logic [ADDRESSLEN-1:0] ZERO_ADDR = ADDRESSLEN'(ZERO_REG);

    logic [XLEN-1:0]       registers [AMOUNT];
    logic [ADDRESSLEN-1:0] rs        [2];
    logic [XLEN-1:0]       rdata_next[2];
    logic                  rbusy_next[2];

    assign rs[0] = rs1;
    assign rs[1] = rs2;

    placar_registrador #(
        .AMOUNT     (AMOUNT),
        .ADDRESSLEN (ADDRESSLEN)
    ) u_placar (
        .clk          (clk),
        .reset        (reset),
        .wEn          (wEn),
        .rd           (rd),
        .resEn        (resEn),
        .resAddr      (resAddr),
        .flush        (flush),
        .busy         (busy),
        .pendingCount (pendingCount)
    );

    // Read-port selection: zero register, then same-cycle write bypass, then storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic res_hit;
            res_hit       = resEn && (resAddr == rs[p]);
            rdata_next[p] = registers[rs[p]];
            rbusy_next[p] = busy[rs[p]] | res_hit;
            if (rs[p] == ZERO_ADDR) begin
                rdata_next[p] = '0;
                rbusy_next[p] = 1'b0;
            end else if (wEn && rd == rs[p]) begin
                rdata_next[p] = data;
                rbusy_next[p] = res_hit;
            end
        end
    end

    // Storage array; register 0 is never written and stays at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset because the bank must read all-zero after reset; this rules out a RAM macro.
            for (int i = 0; i < AMOUNT; i++) begin
                registers[i] <= '0;
            end
        end else if (wEn && rd != ZERO_ADDR) begin
            registers[rd] <= data;
        end
    end

    // Registered read ports; rEn low holds the previous sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1     <= '0;
            r2     <= '0;
            r1Busy <= 1'b0;
            r2Busy <= 1'b0;
        end else if (rEn) begin
            r1     <= rdata_next[0];
            r2     <= rdata_next[1];
            r1Busy <= rbusy_next[0];
            r2Busy <= rbusy_next[1];
        end
    end

endmodule

// File: tb/tb_banco_registrador_placar.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a behavioural model of the register bank and scoreboard.
module tb_banco_registrador_placar;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rEn = 1'b0;
    logic [3:0]  rs1 = '0, rs2 = '0;
    logic [31:0] r1, r2;
    logic        r1Busy, r2Busy;
    logic        wEn = 1'b0;
    logic [3:0]  rd = '0;
    logic [31:0] data = '0;
    logic        resEn = 1'b0;
    logic [3:0]  resAddr = '0;
    logic        flush = 1'b0;
    logic [15:0] busy;
    logic [4:0]  pendingCount;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_regs [16];
    int          m_busy [16];
    logic [31:0] m_r1, m_r2;
    logic        m_r1b, m_r2b;

    banco_registrador_placar dut (
        .clk          (clk),
        .reset        (reset),
        .rEn          (rEn),
        .rs1          (rs1),
        .rs2          (rs2),
        .r1           (r1),
        .r2           (r2),
        .r1Busy       (r1Busy),
        .r2Busy       (r2Busy),
        .wEn          (wEn),
        .rd           (rd),
        .data         (data),
        .resEn        (resEn),
        .resAddr      (resAddr),
        .flush        (flush),
        .busy         (busy),
        .pendingCount (pendingCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 16; i++) c += (m_busy[i] != 0) ? 1 : 0;
        return c;
    endfunction

    function automatic logic [15:0] m_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = (m_busy[i] != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_r1 = '0; m_r2 = '0; m_r1b = 1'b0; m_r2b = 1'b0;
    endtask

    // What a read port captures for address a, given pre-edge state and this cycle's inputs.
    task automatic model_port(input logic [3:0] a, output logic [31:0] d, output logic b);
        logic rh;
        rh = resEn && (resAddr == a);
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else if (wEn && rd == a) begin
            d = data; b = rh;
        end else begin
            d = m_regs[a]; b = (m_busy[a] != 0) || rh;
        end
    endtask

    task automatic model_edge();
        logic [31:0] d1, d2;
        logic        b1, b2;
        if (rEn) begin
            model_port(rs1, d1, b1);
            model_port(rs2, d2, b2);
            m_r1 = d1; m_r1b = b1;
            m_r2 = d2; m_r2b = b2;
        end
        if (flush) for (int i = 0; i < 16; i++) m_busy[i] = 0;
        if (wEn && rd != 0) begin
            m_regs[rd] = data;
            m_busy[rd] = 0;
        end
        if (resEn && resAddr != 0) m_busy[resAddr] = 1;
    endtask

    task automatic check_all();
        check("r1", r1, m_r1);
        check("r2", r2, m_r2);
        check("r1Busy", r1Busy, m_r1b);
        check("r2Busy", r2Busy, m_r2b);
        check("busy", busy, m_vec());
        check("pendingCount", pendingCount, m_count());
    endtask

    task automatic idle();
        rEn = 1'b0; wEn = 1'b0; resEn = 1'b0; flush = 1'b0;
    endtask

    // One clock: inputs already set; model follows the edge, outputs compared at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        idle();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] v);
        wEn = 1'b1; rd = a; data = v; step();
    endtask

    task automatic do_reserve(input logic [3:0] a);
        resEn = 1'b1; resAddr = a; step();
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] b);
        rEn = 1'b1; rs1 = a; rs2 = b; step();
    endtask

    initial begin
        model_reset();

        // Reset held low: everything zero.
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;

        // Load registers, reserve a few, sample non-zero data.
        for (int i = 1; i < 16; i++) do_write(i[3:0], 32'hA5A5_0000 + i);
        do_reserve(4'd6);
        do_reserve(4'd11);
        do_read(4'd1, 4'd6);
        check("preload r1", r1, 32'hA5A5_0001);

        // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async r1", r1, 32'h0);
        check("async r2Busy", r2Busy, 1'b0);
        check("async busy", busy, 16'h0);
        check("async count", pendingCount, 5'd0);
        // Activity while held in reset is ignored.
        wEn = 1'b1; rd = 4'd2; data = 32'hFFFF_FFFF; resEn = 1'b1; resAddr = 4'd2; rEn = 1'b1; rs1 = 4'd2;
        @(posedge clk);
        @(negedge clk);
        check_all();
        idle();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_read(4'(2 * i), 4'(2 * i + 1));
            check("post-reset r1", r1, 32'h0);
            check("post-reset r2", r2, 32'h0);
        end

        // Write then read; zero register ignores writes.
        do_write(4'd5, 32'hDEAD_BEEF);
        do_read(4'd5, 4'd0);
        check("wr r1", r1, 32'hDEAD_BEEF);
        check("wr r2", r2, 32'h0);
        do_write(4'd0, 32'h1234_5678);
        do_read(4'd0, 4'd5);
        check("r0 r1", r1, 32'h0);

        // Same-cycle write bypass.
        wEn = 1'b1; rd = 4'd7; data = 32'h0000_1234; rEn = 1'b1; rs1 = 4'd7; rs2 = 4'd7;
        step();
        check("bypass r1", r1, 32'h0000_1234);
        check("bypass r1Busy", r1Busy, 1'b0);

        // Scoreboard reserve/release.
        do_reserve(4'd3);
        do_reserve(4'd4);
        do_reserve(4'd3);
        check("sb busy", busy, 16'h0018);
        check("sb count", pendingCount, 5'd2);
        do_read(4'd3, 4'd2);
        check("sb r1Busy", r1Busy, 1'b1);
        check("sb r2Busy", r2Busy, 1'b0);
        do_write(4'd3, 32'h3333_3333);
        check("release busy", busy, 16'h0010);
        check("release count", pendingCount, 5'd1);
        do_reserve(4'd0);
        check("res0 busy", busy, 16'h0010);

        // Reserve wins over same-address release.
        wEn = 1'b1; rd = 4'd9; data = 32'h9999_0000; resEn = 1'b1; resAddr = 4'd9;
        rEn = 1'b1; rs1 = 4'd9; rs2 = 4'd4;
        step();
        check("collide busy9", busy[9], 1'b1);
        check("collide r1", r1, 32'h9999_0000);
        check("collide r1Busy", r1Busy, 1'b1);
        // Flush with simultaneous reserve.
        flush = 1'b1; resEn = 1'b1; resAddr = 4'd2;
        step();
        check("flush busy", busy, 16'h0004);
        check("flush count", pendingCount, 5'd1);

        // rEn low holds read outputs while state changes underneath.
        do_read(4'd5, 4'd2);
        rs1 = 4'd9; rs2 = 4'd3; wEn = 1'b1; rd = 4'd5; data = 32'h0BAD_F00D; resEn = 1'b1; resAddr = 4'd5;
        step();
        check("hold r1", r1, 32'hDEAD_BEEF);
        check("hold r2Busy", r2Busy, 1'b1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            rEn     = ($urandom_range(0, 3) != 0);
            rs1     = 4'($urandom_range(0, 15));
            rs2     = 4'($urandom_range(0, 15));
            wEn     = ($urandom_range(0, 1) != 0);
            rd      = ($urandom_range(0, 3) == 0) ? rs1 : 4'($urandom_range(0, 15));
            data    = $urandom;
            resEn   = ($urandom_range(0, 1) != 0);
            resAddr = ($urandom_range(0, 4) == 0) ? rd : 4'($urandom_range(0, 15));
            flush   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
